// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Front-panel controller for the stopwatch counter. It debounces the
//            buttons and the switch, then runs the RUN/PAUSE/ADJUST sequencer.
// Options  : define AUTO_REPEAT_EN to make a held pause button auto-repeat in ADJ
// Revision : 1.0  initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       btn_sel,
  input  logic       sw_adj,
  input  logic [3:0] digit_in,
  output logic       paused,
  output logic       adj,
  output logic [2:0] adj_sel,
  output logic [3:0] adj_val,
  output logic [1:0] dig_ptr,
  output logic       clr
);

  localparam int              c_dw       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_dw-1:0] c_deb_last = c_dw'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      c_no_write = 3'd5;

  typedef enum logic [1:0] {
    S_PAUSE = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2,
    S_ADJ   = 2'd3
  } state_t;

  // Bit order: 0 pause, 1 reset, 2 sel, 3 adjust switch
  logic [3:0] raw, sync1_q, sync2_q, deb_lvl;
  logic [2:0] prev_q, prev_d, pulse;

  assign raw = {sw_adj, btn_sel, btn_reset, btn_pause};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [c_dw-1:0] cnt_q, cnt_d;
    logic            lvl_q, lvl_d;

    // The count only runs while the sample disagrees with the accepted level.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync2_q[i] != lvl_q) begin
        if (cnt_q == c_deb_last) lvl_d = sync2_q[i];
        else                     cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign deb_lvl[i] = lvl_q;
  end

  assign prev_d = deb_lvl[2:0];
  assign pulse  = deb_lvl[2:0] & ~prev_q;

  logic       pause_pulse, reset_pulse, sel_pulse, sw_lvl, rep_fire;
  assign pause_pulse = pulse[0];
  assign reset_pulse = pulse[1];
  assign sel_pulse   = pulse[2];
  assign sw_lvl      = deb_lvl[3];

  state_t     state_q, state_d;
  logic [3:0] adj_val_q, adj_val_d, limit;
  logic [1:0] dig_ptr_q, dig_ptr_d;
  logic       clr_q, clr_d;

`ifdef AUTO_REPEAT_EN
  localparam int              c_rw       = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [c_rw-1:0] c_rep_last = c_rw'(REPEAT_CYCLES - 1);

  logic [c_rw-1:0] rep_cnt_q, rep_cnt_d;

  // Restarts whenever the hold is broken: release, a fresh edge, or leaving ADJ.
  always_comb begin
    rep_cnt_d = '0;
    rep_fire  = 1'b0;
    if (state_q == S_ADJ && deb_lvl[0] && !pause_pulse) begin
      if (rep_cnt_q == c_rep_last) rep_fire  = 1'b1;
      else                         rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end
`else
  logic unused_repeat;
  assign unused_repeat = |REPEAT_CYCLES;
  assign rep_fire      = 1'b0;
`endif

  assign limit = (dig_ptr_q == 2'd1) ? 4'd5 : 4'd9;

  always_comb begin
    state_d   = state_q;
    adj_val_d = adj_val_q;
    dig_ptr_d = dig_ptr_q;
    clr_d     = 1'b0;
    case (state_q)
      S_PAUSE, S_RUN: begin
        if (sw_lvl)           state_d = S_LOAD;
        else if (reset_pulse) clr_d   = 1'b1;
        else if (pause_pulse) state_d = (state_q == S_PAUSE) ? S_RUN : S_PAUSE;
      end
      S_LOAD: begin
        adj_val_d = (digit_in > limit) ? 4'd0 : digit_in;
        if (!sw_lvl) begin
          state_d = S_PAUSE;
        end else begin
          clr_d   = reset_pulse;
          state_d = S_ADJ;
        end
      end
      default: begin
        // A clear is followed by a reload once the counter has actually cleared.
        if (!sw_lvl) begin
          state_d = S_PAUSE;
        end else if (reset_pulse) begin
          clr_d = 1'b1;
        end else if (clr_q) begin
          state_d = S_LOAD;
        end else if (sel_pulse) begin
          dig_ptr_d = dig_ptr_q + 2'd1;
          state_d   = S_LOAD;
        end else if (pause_pulse || rep_fire) begin
          adj_val_d = (adj_val_q >= limit) ? 4'd0 : adj_val_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_PAUSE;
      adj_val_q <= 4'd0;
      dig_ptr_q <= 2'd0;
      clr_q     <= 1'b0;
      prev_q    <= '0;
    end else begin
      state_q   <= state_d;
      adj_val_q <= adj_val_d;
      dig_ptr_q <= dig_ptr_d;
      clr_q     <= clr_d;
      prev_q    <= prev_d;
    end
  end

  assign paused  = (state_q != S_RUN);
  assign adj     = (state_q == S_LOAD) || (state_q == S_ADJ);
  assign adj_sel = (state_q == S_ADJ) ? {1'b0, dig_ptr_q} : c_no_write;
  assign adj_val = adj_val_q;
  assign dig_ptr = dig_ptr_q;
  assign clr     = clr_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Directed bench for stopwatch_ctrl with a queue of expected outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
  localparam int REP = 8;

  logic       clk = 1'b0;
  logic       rst, btn_pause, btn_reset, btn_sel, sw_adj;
  logic [3:0] digit_in;
  logic       paused, adj, clr;
  logic [2:0] adj_sel;
  logic [3:0] adj_val;
  logic [1:0] dig_ptr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [11:0] value;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_pause(btn_pause),
    .btn_reset(btn_reset),
    .btn_sel  (btn_sel),
    .sw_adj   (sw_adj),
    .digit_in (digit_in),
    .paused   (paused),
    .adj      (adj),
    .adj_sel  (adj_sel),
    .adj_val  (adj_val),
    .dig_ptr  (dig_ptr),
    .clr      (clr)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected vector layout: {paused, adj, adj_sel, adj_val, dig_ptr, clr}
  task automatic expect_out(input string tag, input logic p, input logic a,
                            input logic [2:0] s, input logic [3:0] v,
                            input logic [1:0] d, input logic c);
    exp_t e;
    e.tag   = tag;
    e.value = {p, a, s, v, d, c};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [11:0] obs;
    obs = {paused, adj, adj_sel, adj_val, dig_ptr, clr};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed %03h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.value) else begin
        errors++;
        $error("FAIL %s: observed %03h expected %03h", e.tag, obs, e.value);
      end
    end
  endtask

  // which: 0 pause, 1 reset, 2 sel; hold long enough to debounce, then settle
  task automatic press(input int which);
    case (which)
      0:       btn_pause = 1'b1;
      1:       btn_reset = 1'b1;
      default: btn_sel   = 1'b1;
    endcase
    cyc(10);
    btn_pause = 1'b0;
    btn_reset = 1'b0;
    btn_sel   = 1'b0;
    cyc(10);
  endtask

  initial begin
    rst = 1'b1; btn_pause = 1'b0; btn_reset = 1'b0; btn_sel = 1'b0;
    sw_adj = 1'b0; digit_in = 4'd0;
    cyc(3);
    rst = 1'b0;
    expect_out("reset_state", 1, 0, 5, 0, 0, 0); check_out();

    // Press latency: raw edge to paused falling is 2 + DEB + 1 clocks
    btn_pause = 1'b1;
    expect_out("pause_latency_6", 1, 0, 5, 0, 0, 0); cyc(6); check_out();
    expect_out("pause_latency_7", 0, 0, 5, 0, 0, 0); cyc(1); check_out();
    cyc(3); btn_pause = 1'b0; cyc(10);
    expect_out("hold_one_toggle", 0, 0, 5, 0, 0, 0); check_out();

    btn_pause = 1'b1; cyc(3); btn_pause = 1'b0; cyc(10);
    expect_out("glitch_ignored", 0, 0, 5, 0, 0, 0); check_out();

    // Reset button in RUN: single clr pulse, still running
    btn_reset = 1'b1;
    expect_out("run_clr_before", 0, 0, 5, 0, 0, 0); cyc(6); check_out();
    expect_out("run_clr_pulse",  0, 0, 5, 0, 0, 1); cyc(1); check_out();
    expect_out("run_clr_after",  0, 0, 5, 0, 0, 0); cyc(1); check_out();
    cyc(2); btn_reset = 1'b0; cyc(10);

    expect_out("toggle_pause", 1, 0, 5, 0, 0, 0); press(0); check_out();
    expect_out("toggle_run",   0, 0, 5, 0, 0, 0); press(0); check_out();
    expect_out("toggle_pause2", 1, 0, 5, 0, 0, 0); press(0); check_out();

    // Enter adjust on digit 0 holding 7
    digit_in = 4'd7; sw_adj = 1'b1;
    expect_out("load_cycle", 1, 1, 5, 0, 0, 0); cyc(7); check_out();
    expect_out("adj_entry",  1, 1, 0, 7, 0, 0); cyc(1); check_out();
    cyc(5);
    expect_out("inc_8",      1, 1, 0, 8, 0, 0); press(0); check_out();
    expect_out("inc_9",      1, 1, 0, 9, 0, 0); press(0); check_out();
    expect_out("wrap_9_0",   1, 1, 0, 0, 0, 0); press(0); check_out();

    digit_in = 4'd4;
    expect_out("sel_ptr1",   1, 1, 1, 4, 1, 0); press(2); check_out();
    expect_out("inc_5",      1, 1, 1, 5, 1, 0); press(0); check_out();
    expect_out("wrap_5_0",   1, 1, 1, 0, 1, 0); press(0); check_out();
    expect_out("inc_1",      1, 1, 1, 1, 1, 0); press(0); check_out();

    // Reset button in ADJ: clr, then LOAD of the cleared digit
    btn_reset = 1'b1;
    expect_out("adj_clr_pulse", 1, 1, 1, 1, 1, 1); cyc(7); check_out();
    digit_in = 4'd0;
    expect_out("adj_clr_load",  1, 1, 5, 1, 1, 0); cyc(1); check_out();
    expect_out("adj_clr_reload", 1, 1, 1, 0, 1, 0); cyc(1); check_out();
    cyc(1); btn_reset = 1'b0; cyc(10);

    // Reset and sel together: sel dropped, pointer unchanged
    expect_out("inc_before_dual", 1, 1, 1, 1, 1, 0); press(0); check_out();
    btn_reset = 1'b1; btn_sel = 1'b1;
    expect_out("dual_clr_pulse", 1, 1, 1, 1, 1, 1); cyc(7); check_out();
    expect_out("dual_load",      1, 1, 5, 1, 1, 0); cyc(1); check_out();
    expect_out("dual_ptr_kept",  1, 1, 1, 0, 1, 0); cyc(1); check_out();
    cyc(1); btn_reset = 1'b0; btn_sel = 1'b0; cyc(10);

    // Walk pointer round; digit 1 clamps an out-of-range value to 0
    digit_in = 4'd7;
    expect_out("sel_ptr2",    1, 1, 2, 7, 2, 0); press(2); check_out();
    expect_out("sel_ptr3",    1, 1, 3, 7, 3, 0); press(2); check_out();
    expect_out("sel_ptr0",    1, 1, 0, 7, 0, 0); press(2); check_out();
    expect_out("clamp_ptr1",  1, 1, 1, 0, 1, 0); press(2); check_out();

    sw_adj = 1'b0; cyc(10);
    expect_out("leave_adj",   1, 0, 5, 0, 1, 0); check_out();
    digit_in = 4'd2; sw_adj = 1'b1; cyc(10);
    expect_out("reenter_ptr", 1, 1, 1, 2, 1, 0); check_out();

    rst = 1'b1; sw_adj = 1'b0; cyc(1);
    expect_out("rst_mid_adj", 1, 0, 5, 0, 0, 0); check_out();
    cyc(1); rst = 1'b0; cyc(2);

    // Held increment in ADJ from value 0
    digit_in = 4'd0; sw_adj = 1'b1; cyc(10);
    expect_out("hold_entry", 1, 1, 0, 0, 0, 0); check_out();
    btn_pause = 1'b1;
`ifdef AUTO_REPEAT_EN
    expect_out("rep_press", 1, 1, 0, 1, 0, 0); cyc(7); check_out();
    expect_out("rep_wait",  1, 1, 0, 1, 0, 0); cyc(7); check_out();
    expect_out("rep_8",     1, 1, 0, 2, 0, 0); cyc(1); check_out();
    expect_out("rep_16",    1, 1, 0, 3, 0, 0); cyc(8); check_out();
    cyc(7); btn_pause = 1'b0;
    expect_out("rep_24",    1, 1, 0, 4, 0, 0); cyc(1); check_out();
    expect_out("rep_stop",  1, 1, 0, 4, 0, 0); cyc(12); check_out();
`else
    expect_out("hold_press",    1, 1, 0, 1, 0, 0); cyc(7); check_out();
    expect_out("hold_no_repeat", 1, 1, 0, 1, 0, 0); cyc(23); check_out();
    btn_pause = 1'b0; cyc(12);
    expect_out("hold_release",  1, 1, 0, 1, 0, 0); check_out();
`endif

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
